// File: rtl/div_ctrl_if.sv
// Configuration/control and period-output bundle for the divider sequencer.
interface div_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BW    = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_div;
  logic [BW-1:0]    cfg_burst;
  logic             start;
  logic             stop;
  logic             tick;
  logic             done;
  logic             busy;
  logic [WIDTH-1:0] phase;

  modport master (
    output cfg_valid, cfg_div, cfg_burst, start, stop,
    input  cfg_ready, tick, done, busy, phase
  );

  modport slave (
    input  cfg_valid, cfg_div, cfg_burst, start, stop,
    output cfg_ready, tick, done, busy, phase
  );
endinterface

// File: rtl/div_ctrl.sv
// Divider sequencer: emits a tick every D clocks, continuously or for B ticks,
// with divisor/burst changes deferred to the next period boundary while running.
module div_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned BW    = 8
) (
  input  logic        clk,
  input  logic        rst,
  div_ctrl_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic [WIDTH-1:0] d_act_q, d_act_d;
  logic [BW-1:0]    b_rem_q, b_rem_d;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] d_pend_q, d_pend_d;
  logic [BW-1:0]    b_pend_q, b_pend_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;

  logic             cfg_ready_c;
  logic             cfg_fire_c;
  logic [WIDTH-1:0] cfg_div_eff_c;
  logic             period_end_c;

  // Only one reconfiguration may be queued while running.
  assign cfg_ready_c   = (state_q == ST_IDLE) || !pend_q;
  assign cfg_fire_c    = bus.cfg_valid && cfg_ready_c;
  assign cfg_div_eff_c = (bus.cfg_div == '0) ? WIDTH'(1) : bus.cfg_div;
  assign period_end_c  = (phase_q == (d_act_q - WIDTH'(1)));

  assign bus.cfg_ready = cfg_ready_c;
  assign bus.tick      = tick_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.phase     = phase_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      d_act_q  <= WIDTH'(1);
      b_rem_q  <= '0;
      pend_q   <= 1'b0;
      d_pend_q <= WIDTH'(1);
      b_pend_q <= '0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      d_act_q  <= d_act_d;
      b_rem_q  <= b_rem_d;
      pend_q   <= pend_d;
      d_pend_q <= d_pend_d;
      b_pend_q <= b_pend_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    d_act_d  = d_act_q;
    b_rem_d  = b_rem_q;
    pend_d   = pend_q;
    d_pend_d = d_pend_q;
    b_pend_d = b_pend_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        // Config on the start edge lands in the active registers before the run begins.
        if (cfg_fire_c) begin
          d_act_d = cfg_div_eff_c;
          b_rem_d = bus.cfg_burst;
        end
        if (bus.start) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (bus.stop) begin
          // Abort wins over a due tick; any queued or arriving config becomes active.
          state_d = ST_IDLE;
          phase_d = '0;
          if (pend_q) begin
            d_act_d = d_pend_q;
            b_rem_d = b_pend_q;
            pend_d  = 1'b0;
          end
          if (cfg_fire_c) begin
            d_act_d = cfg_div_eff_c;
            b_rem_d = bus.cfg_burst;
          end
        end else if (period_end_c) begin
          phase_d = '0;
          tick_d  = 1'b1;
          if (b_rem_q != '0) begin
            b_rem_d = b_rem_q - BW'(1);
            if (b_rem_q == BW'(1)) begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
          if (pend_q) begin
            d_act_d = d_pend_q;
            b_rem_d = b_pend_q;
            pend_d  = 1'b0;
          end
          // A config arriving on a tick edge waits for the next boundary, unless the run just ended.
          if (cfg_fire_c) begin
            if (state_d == ST_IDLE) begin
              d_act_d = cfg_div_eff_c;
              b_rem_d = bus.cfg_burst;
            end else begin
              pend_d   = 1'b1;
              d_pend_d = cfg_div_eff_c;
              b_pend_d = bus.cfg_burst;
            end
          end
        end else begin
          phase_d = phase_q + WIDTH'(1);
          if (cfg_fire_c) begin
            pend_d   = 1'b1;
            d_pend_d = cfg_div_eff_c;
            b_pend_d = bus.cfg_burst;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed and randomized bench for div_ctrl against a per-edge behavioural model.
module tb_div_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned BW    = 8;

  logic clk;
  logic rst;

  div_ctrl_if #(.WIDTH(WIDTH), .BW(BW)) bus ();

  div_ctrl #(.WIDTH(WIDTH), .BW(BW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int d;
    int b;
  } cfg_t;

  int   checks;
  int   failures;
  int   tick_seen;
  int   done_seen;

  // Model: run flag, cycles into the current period, active divisor, ticks left (0 = endless).
  bit   m_known;
  bit   m_run;
  int   m_cnt;
  int   m_dact;
  int   m_left;
  cfg_t m_pq[$];
  bit   e_tick;
  bit   e_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit v, input int div, input int burst,
                            input bit st, input bit sp, input bit r);
    bit   ready;
    bit   fire;
    bit   last;
    int   eff;
    cfg_t c;
    e_tick = 1'b0;
    e_done = 1'b0;
    if (r) begin
      m_run  = 1'b0;
      m_cnt  = 0;
      m_dact = 1;
      m_left = 0;
      m_pq.delete();
      m_known = 1'b1;
      return;
    end
    ready = !m_run || (m_pq.size() == 0);
    fire  = v && ready;
    eff   = (div == 0) ? 1 : div;
    c.d   = eff;
    c.b   = burst;
    if (!m_run) begin
      m_cnt = 0;
      if (fire) begin
        m_dact = eff;
        m_left = burst;
      end
      if (st) m_run = 1'b1;
    end else if (sp) begin
      m_run = 1'b0;
      m_cnt = 0;
      if (m_pq.size() != 0) begin
        cfg_t p;
        p = m_pq.pop_front();
        m_dact = p.d;
        m_left = p.b;
      end
      if (fire) begin
        m_dact = eff;
        m_left = burst;
      end
    end else if (m_cnt + 1 == m_dact) begin
      e_tick = 1'b1;
      m_cnt  = 0;
      last   = (m_left == 1);
      if (m_left > 0) m_left = m_left - 1;
      if (last) begin
        e_done = 1'b1;
        m_run  = 1'b0;
      end
      if (m_pq.size() != 0) begin
        cfg_t p;
        p = m_pq.pop_front();
        m_dact = p.d;
        m_left = p.b;
      end
      if (fire) begin
        if (!m_run) begin
          m_dact = eff;
          m_left = burst;
        end else begin
          m_pq.push_back(c);
        end
      end
    end else begin
      m_cnt = m_cnt + 1;
      if (fire) m_pq.push_back(c);
    end
  endtask

  // Drive one cycle of inputs, check the handshake before the edge and registered outputs after it.
  task automatic step(input bit v, input int div, input int burst,
                      input bit st, input bit sp, input bit r);
    bus.cfg_valid = v;
    bus.cfg_div   = WIDTH'(div);
    bus.cfg_burst = BW'(burst);
    bus.start     = st;
    bus.stop      = sp;
    rst           = r;
    #1;
    if (m_known)
      check("cfg_ready", 32'(bus.cfg_ready), 32'((!m_run || (m_pq.size() == 0)) ? 1 : 0));
    model_edge(v, div, burst, st, sp, r);
    @(posedge clk);
    #1;
    check("tick",  32'(bus.tick),  32'(e_tick));
    check("done",  32'(bus.done),  32'(e_done));
    check("busy",  32'(bus.busy),  32'(m_run));
    check("phase", 32'(bus.phase), 32'(m_cnt));
    if (bus.tick === 1'b1) tick_seen++;
    if (bus.done === 1'b1) done_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    tick_seen = 0;
    done_seen = 0;
    m_known   = 1'b0;
    m_run     = 1'b0;
    m_cnt     = 0;
    m_dact    = 1;
    m_left    = 0;
    rst           = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_div   = '0;
    bus.cfg_burst = '0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    @(negedge clk);

    // Reset values.
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    check("rst_cfg_ready", 32'(bus.cfg_ready), 32'd1);

    // Continuous D=4: ticks every 4 cycles, no done.
    step(1'b1, 4, 0, 1'b1, 1'b0, 1'b0);
    tick_seen = 0;
    done_seen = 0;
    idle(16);
    check("d4_tick_count", 32'(tick_seen), 32'd4);
    check("d4_done_count", 32'(done_seen), 32'd0);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);

    // Burst D=3 B=2: two ticks, done with the second, then silence.
    step(1'b1, 3, 2, 1'b1, 1'b0, 1'b0);
    tick_seen = 0;
    done_seen = 0;
    idle(10);
    check("b2_tick_count", 32'(tick_seen), 32'd2);
    check("b2_done_count", 32'(done_seen), 32'd1);

    // Running D=5, reconfigure to D=2 mid-period.
    step(1'b1, 5, 0, 1'b1, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 2, 0, 1'b0, 1'b0, 1'b0);
    check("reconf_ready_low", 32'(bus.cfg_ready), 32'd0);
    tick_seen = 0;
    idle(3);
    check("reconf_first_tick", 32'(tick_seen), 32'd1);
    tick_seen = 0;
    idle(10);
    check("reconf_d2_ticks", 32'(tick_seen), 32'd5);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);

    // Stop on a tick-due edge suppresses the tick.
    step(1'b1, 4, 0, 1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    check("stop_no_tick", 32'(bus.tick), 32'd0);
    check("stop_phase",   32'(bus.phase), 32'd0);

    // D=0 treated as 1, burst of 3, config on the start edge.
    step(1'b1, 0, 3, 1'b1, 1'b0, 1'b0);
    tick_seen = 0;
    done_seen = 0;
    idle(5);
    check("d0_tick_count", 32'(tick_seen), 32'd3);
    check("d0_done_count", 32'(done_seen), 32'd1);

    // Maximum divisor, single-tick burst.
    step(1'b1, 255, 1, 1'b1, 1'b0, 1'b0);
    tick_seen = 0;
    idle(260);
    check("dmax_tick_count", 32'(tick_seen), 32'd1);

    // Reset mid-burst discards config; next start runs D=1 continuous.
    step(1'b1, 3, 5, 1'b1, 1'b0, 1'b0);
    idle(4);
    step(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    tick_seen = 0;
    idle(6);
    check("post_rst_ticks", 32'(tick_seen), 32'd6);
    step(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      bit v, st, sp, r;
      int dv, bu;
      v  = ($urandom_range(0, 3) == 0);
      dv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 6));
      bu = int'($urandom_range(0, 4));
      st = ($urandom_range(0, 5) == 0);
      sp = ($urandom_range(0, 30) == 0);
      r  = ($urandom_range(0, 400) == 0);
      step(v, dv, bu, st, sp, r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
